// File: rtl/playbus_target.sv
// PlayBus target: synchronised bus decode, RAM/ROM/switch read mux, RAM write FSM, LED latch.
// Optional macro WRITE_COUNT_EN builds the saturating committed-write counter on WCNT.
module playbus_target #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          CK1KHZ,
  input  logic          n_CLR,
  input  logic          n_ROMO,
  input  logic          n_RAMO,
  input  logic          n_SWBEN,
  input  logic          n_RAMW,
  input  logic          LEDLTCH,
  input  logic [AW-1:0] ADD,
  input  logic [DW-1:0] DIN,
  input  logic [DW-1:0] SW,
  output logic [DW-1:0] DOUT,
  output logic          DOE,
  output logic [DW-1:0] LED,
  output logic          ERR,
  output logic [7:0]    WCNT
);

  // state    | meaning
  // W_IDLE   | waiting for n_RAMW to go low
  // W_ARMED  | n_RAMW low, waiting for release; n_RAMO low here aborts the write
  // W_COMMIT | one cycle: write DIN to RAM[ADD] unless aborted
  typedef enum logic [1:0] {W_IDLE, W_ARMED, W_COMMIT} wstate_t;

  logic          r_romo_s1, r_romo_s2;
  logic          r_ramo_s1, r_ramo_s2;
  logic          r_swben_s1, r_swben_s2;
  logic          r_ramw_s1, r_ramw_s2;
  logic          r_ledl_s1, r_ledl_s2, r_ledl_s3;
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_dout;
  logic          r_doe;
  logic [DW-1:0] r_led;
  logic          r_led_ld;
  logic          r_err;
  logic          r_abort;
  wstate_t       r_wstate;

  logic [2:0]    w_en;
  logic          w_multi;
  logic          w_led_rise;
  logic          w_commit;
  logic          w_err_set;
  logic [DW-1:0] w_rom;

  always_ff @(posedge CK1KHZ or negedge n_CLR) begin
    if (!n_CLR) begin
      r_romo_s1  <= 1'b1;  r_romo_s2  <= 1'b1;
      r_ramo_s1  <= 1'b1;  r_ramo_s2  <= 1'b1;
      r_swben_s1 <= 1'b1;  r_swben_s2 <= 1'b1;
      r_ramw_s1  <= 1'b1;  r_ramw_s2  <= 1'b1;
      r_ledl_s1  <= 1'b0;  r_ledl_s2  <= 1'b0;  r_ledl_s3 <= 1'b0;
    end else begin
      r_romo_s1  <= n_ROMO;   r_romo_s2  <= r_romo_s1;
      r_ramo_s1  <= n_RAMO;   r_ramo_s2  <= r_ramo_s1;
      r_swben_s1 <= n_SWBEN;  r_swben_s2 <= r_swben_s1;
      r_ramw_s1  <= n_RAMW;   r_ramw_s2  <= r_ramw_s1;
      r_ledl_s1  <= LEDLTCH;  r_ledl_s2  <= r_ledl_s1;  r_ledl_s3 <= r_ledl_s2;
    end
  end

  assign w_en       = {~r_romo_s2, ~r_ramo_s2, ~r_swben_s2};
  assign w_multi    = (w_en[2] & w_en[1]) | (w_en[2] & w_en[0]) | (w_en[1] & w_en[0]);
  assign w_led_rise = r_ledl_s2 & ~r_ledl_s3;
  assign w_commit   = (r_wstate == W_COMMIT) & ~r_abort;
  assign w_err_set  = w_multi
                    | ((r_wstate == W_ARMED) & ~r_ramo_s2)
                    | (w_led_rise & ~r_doe & ~(|w_en));

  // ROM word is the address bits repeated across the data width
  always_comb begin
    w_rom = '0;
    for (int i = 0; i < DW; i++) w_rom[i] = ADD[i % AW];
  end

  always_ff @(posedge CK1KHZ or negedge n_CLR) begin
    if (!n_CLR) begin
      r_dout <= '0;
      r_doe  <= 1'b0;
    end else begin
      case (w_en)
        3'b100:  begin r_doe <= 1'b1; r_dout <= w_rom;      end
        3'b010:  begin r_doe <= 1'b1; r_dout <= r_mem[ADD]; end
        3'b001:  begin r_doe <= 1'b1; r_dout <= SW;         end
        default: r_doe <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge CK1KHZ or negedge n_CLR) begin
    if (!n_CLR) begin
      r_wstate <= W_IDLE;
      r_abort  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_abort <= 1'b0;
          if (!r_ramw_s2) r_wstate <= W_ARMED;
        end
        W_ARMED: begin
          if (!r_ramo_s2) r_abort <= 1'b1;
          if (r_ramw_s2) r_wstate <= W_COMMIT;
        end
        W_COMMIT: r_wstate <= W_IDLE;
        default:  r_wstate <= W_IDLE;
      endcase
    end
  end

  // Non-blocking write: a same-cycle read of the address sees the old word
  always_ff @(posedge CK1KHZ or negedge n_CLR) begin
    if (!n_CLR) begin
      for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[ADD] <= DIN;
    end
  end

  always_ff @(posedge CK1KHZ or negedge n_CLR) begin
    if (!n_CLR) begin
      r_led    <= '0;
      r_led_ld <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_led_ld <= w_led_rise;
      if (r_led_ld) r_led <= DIN;
      if (w_err_set) r_err <= 1'b1;
    end
  end

`ifdef WRITE_COUNT_EN
  logic [7:0] r_wcnt;

  always_ff @(posedge CK1KHZ or negedge n_CLR) begin
    if (!n_CLR)                           r_wcnt <= 8'h00;
    else if (w_commit && r_wcnt != 8'hFF) r_wcnt <= r_wcnt + 8'h01;
  end

  assign WCNT = r_wcnt;
`else
  assign WCNT = 8'h00;
`endif

  assign DOUT = r_dout;
  assign DOE  = r_doe;
  assign LED  = r_led;
  assign ERR  = r_err;

endmodule

// File: tb/tb_playbus_target.sv
// Scoreboard bench for playbus_target: reads push expected bus words, popped at the DUT's output latency.
module tb_playbus_target;

  logic       CK1KHZ = 1'b0;
  logic       n_CLR = 1'b0;
  logic       n_ROMO = 1'b1, n_RAMO = 1'b1, n_SWBEN = 1'b1, n_RAMW = 1'b1, LEDLTCH = 1'b0;
  logic [3:0] ADD = '0;
  logic [7:0] DIN = '0, SW = '0;
  logic [7:0] DOUT, LED, WCNT;
  logic       DOE, ERR;

  playbus_target #(.DW(8), .AW(4)) dut (
    .CK1KHZ(CK1KHZ), .n_CLR(n_CLR), .n_ROMO(n_ROMO), .n_RAMO(n_RAMO), .n_SWBEN(n_SWBEN),
    .n_RAMW(n_RAMW), .LEDLTCH(LEDLTCH), .ADD(ADD), .DIN(DIN), .SW(SW),
    .DOUT(DOUT), .DOE(DOE), .LED(LED), .ERR(ERR), .WCNT(WCNT)
  );

  always #5 CK1KHZ = ~CK1KHZ;

  typedef struct {
    string      tag;
    logic       doe;
    logic [7:0] dout;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_ram [16];
  logic [7:0] m_wcnt;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_doe"}, {31'd0, DOE}, {31'd0, e.doe});
    check({e.tag, "_dout"}, {24'd0, DOUT}, {24'd0, e.dout});
  endtask

  task automatic model_commit(input logic [3:0] a, input logic [7:0] d);
    m_ram[a] = d;
`ifdef WRITE_COUNT_EN
    if (m_wcnt != 8'hFF) m_wcnt = m_wcnt + 8'h01;
`endif
  endtask

  task automatic do_reset();
    @(negedge CK1KHZ);
    n_CLR = 1'b0;
    n_ROMO = 1'b1; n_RAMO = 1'b1; n_SWBEN = 1'b1; n_RAMW = 1'b1; LEDLTCH = 1'b0;
    #2;
    check("rst_dout", {24'd0, DOUT}, 32'h00);
    check("rst_doe", {31'd0, DOE}, 32'd0);
    check("rst_led", {24'd0, LED}, 32'h00);
    check("rst_err", {31'd0, ERR}, 32'd0);
    check("rst_wcnt", {24'd0, WCNT}, 32'h00);
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_wcnt = 8'h00;
    repeat (2) @(negedge CK1KHZ);
    n_CLR = 1'b1;
    repeat (3) @(negedge CK1KHZ);
  endtask

  // sel: 0 = ROM, 1 = RAM, 2 = switches; bus must be idle (DOE=0) on entry
  task automatic do_read(input string tag, input int sel, input logic [3:0] a);
    exp_t e;
    @(negedge CK1KHZ);
    ADD = a;
    e.tag = tag;
    e.doe = 1'b1;
    case (sel)
      0:       begin n_ROMO = 1'b0;  e.dout = {a, a};   end
      1:       begin n_RAMO = 1'b0;  e.dout = m_ram[a]; end
      default: begin n_SWBEN = 1'b0; e.dout = SW;       end
    endcase
    sb.push_back(e);
    repeat (2) @(posedge CK1KHZ);
    #1 check({tag, "_early"}, {31'd0, DOE}, 32'd0);
    @(posedge CK1KHZ);
    #1 sb_pop();
    @(negedge CK1KHZ);
    n_ROMO = 1'b1; n_RAMO = 1'b1; n_SWBEN = 1'b1;
    repeat (4) @(negedge CK1KHZ);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge CK1KHZ);
    ADD = a; DIN = d; n_RAMW = 1'b0;
    repeat (4) @(negedge CK1KHZ);
    n_RAMW = 1'b1;
    repeat (6) @(negedge CK1KHZ);
    model_commit(a, d);
  endtask

  // n_RAMO falls so its synchronised value first goes low in the commit cycle
  task automatic do_rdw(input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    @(negedge CK1KHZ);
    ADD = a; DIN = d; n_RAMW = 1'b0;
    repeat (4) @(negedge CK1KHZ);
    n_RAMW = 1'b1;
    @(posedge CK1KHZ);
    @(negedge CK1KHZ);
    n_RAMO = 1'b0;
    e.tag = "rdw_old"; e.doe = 1'b1; e.dout = m_ram[a];
    sb.push_back(e);
    repeat (3) @(posedge CK1KHZ);
    #1 sb_pop();
    model_commit(a, d);
    e.tag = "rdw_new"; e.doe = 1'b1; e.dout = m_ram[a];
    sb.push_back(e);
    @(posedge CK1KHZ);
    #1 sb_pop();
    check("rdw_err", {31'd0, ERR}, 32'd0);
    @(negedge CK1KHZ);
    n_RAMO = 1'b1;
    repeat (4) @(negedge CK1KHZ);
  endtask

  initial begin
    logic [3:0] ra;
    logic [7:0] rd;

    do_reset();
    do_read("ram3_reset", 1, 4'd3);
    do_read("rom9", 0, 4'd9);
    do_read("rom0", 0, 4'd0);
    SW = 8'h5A;
    do_read("sw5a", 2, 4'd1);

    do_write(4'd5, 8'hA7);
    do_read("ram5", 1, 4'd5);
    check("wr1_wcnt", {24'd0, WCNT}, {24'd0, m_wcnt});
    check("wr1_err", {31'd0, ERR}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      ra = 4'($urandom_range(0, 15));
      rd = 8'($urandom);
      do_write(ra, rd);
      do_read("ram_rand", 1, ra);
    end
    do_read("ram5_again", 1, 4'd5);
    check("wr_rand_wcnt", {24'd0, WCNT}, {24'd0, m_wcnt});

    do_rdw(4'd6, 8'hC3);
    do_read("ram6", 1, 4'd6);

    // LED latch while the switches drive the bus: one load, held-high strobe ignored
    @(negedge CK1KHZ);
    SW = 8'h3C; DIN = 8'h3C; n_SWBEN = 1'b0;
    repeat (4) @(negedge CK1KHZ);
    LEDLTCH = 1'b1;
    repeat (10) @(negedge CK1KHZ);
    check("led_load", {24'd0, LED}, 32'h3C);
    DIN = 8'h00;
    repeat (6) @(negedge CK1KHZ);
    check("led_hold", {24'd0, LED}, 32'h3C);
    check("led_doe", {31'd0, DOE}, 32'd1);
    check("led_err", {31'd0, ERR}, 32'd0);
    LEDLTCH = 1'b0; n_SWBEN = 1'b1;
    repeat (4) @(negedge CK1KHZ);

    // Bus contention
    n_ROMO = 1'b0; n_SWBEN = 1'b0;
    repeat (4) @(negedge CK1KHZ);
    check("multi_doe", {31'd0, DOE}, 32'd0);
    check("multi_err", {31'd0, ERR}, 32'd1);
    n_ROMO = 1'b1; n_SWBEN = 1'b1;
    repeat (4) @(negedge CK1KHZ);
    check("multi_err_sticky", {31'd0, ERR}, 32'd1);

    // Reset clears RAM and ERR; then a write aborted by n_RAMO
    do_reset();
    do_read("ram5_cleared", 1, 4'd5);
    @(negedge CK1KHZ);
    ADD = 4'd2; DIN = 8'h55; n_RAMO = 1'b0;
    repeat (3) @(negedge CK1KHZ);
    n_RAMW = 1'b0;
    repeat (4) @(negedge CK1KHZ);
    n_RAMW = 1'b1;
    repeat (6) @(negedge CK1KHZ);
    check("abort_ram2", {24'd0, DOUT}, 32'h00);
    check("abort_err", {31'd0, ERR}, 32'd1);
    check("abort_wcnt", {24'd0, WCNT}, 32'h00);
    n_RAMO = 1'b1;
    repeat (4) @(negedge CK1KHZ);

    // LED strobe on a floating bus
    do_reset();
    DIN = 8'h81;
    LEDLTCH = 1'b1;
    repeat (6) @(negedge CK1KHZ);
    check("float_led", {24'd0, LED}, 32'h81);
    check("float_err", {31'd0, ERR}, 32'd1);
    LEDLTCH = 1'b0;

    // Reset while armed abandons the write
    do_reset();
    ADD = 4'd7; DIN = 8'hFF; n_RAMW = 1'b0;
    repeat (4) @(negedge CK1KHZ);
    n_CLR = 1'b0; n_RAMW = 1'b1;
    repeat (2) @(negedge CK1KHZ);
    n_CLR = 1'b1;
    repeat (6) @(negedge CK1KHZ);
    do_read("ram7_abandoned", 1, 4'd7);
    check("rstmid_wcnt", {24'd0, WCNT}, 32'h00);

    for (int i = 0; i < 256; i++) do_write(4'(i), 8'(i ^ 8'h5A));
    check("wcnt_sat", {24'd0, WCNT}, {24'd0, m_wcnt});
    do_write(4'd15, 8'h99);
    check("wcnt_sat2", {24'd0, WCNT}, {24'd0, m_wcnt});
    do_read("ram15_final", 1, 4'd15);
    do_read("ram3_final", 1, 4'd3);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/playbus_target.md
PLAYBUS_TARGET -- requirements
Module: playbus_target

Interface
REQ-001 SHALL have parameters: DW, default 8, data bus width; AW, default 4, address width.
REQ-002 SHALL have port CK1KHZ  input  1  sampling clock; all state on its rising edge.
REQ-003 SHALL have port n_CLR  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports n_ROMO, n_RAMO, n_SWBEN  input  1 each  active-low bus source enables from the PlayBus controller.
REQ-005 SHALL have ports n_RAMW  input  1  active-low RAM write strobe; LEDLTCH  input  1  active-high LED latch strobe.
REQ-006 SHALL have port ADD  input  AW  bus address.
REQ-007 SHALL have port DIN  input  DW  data bus as seen at the pins.
REQ-008 SHALL have port SW  input  DW  switch inputs.
REQ-009 SHALL have port DOUT  output  DW  data driven to the bus.
REQ-010 SHALL have port DOE  output  1  bus drive enable for DOUT.
REQ-011 SHALL have port LED  output  DW  LED latch contents.
REQ-012 SHALL have port ERR  output  1  sticky protocol-error flag.
REQ-013 SHALL have port WCNT  output  8  committed-write counter.

Function
REQ-014 SHALL pass n_ROMO, n_RAMO, n_SWBEN, n_RAMW, LEDLTCH through 2-flop synchronisers; synchronised values drive all decisions.
REQ-015 SHALL contain RAM of 2^AW words x DW bits; ROM is fixed: ROM[a] = a replicated to fill DW bits.
REQ-016 SHALL register DOUT/DOE; a pin-level change of a source enable is reflected at DOUT/DOE exactly 3 CK1KHZ edges later.
REQ-017 Exactly one synchronised source enable active: DOE=1, DOUT = ROM[ADD], RAM[ADD] or SW respectively.
REQ-018 No source enable active: DOE=0, DOUT holds last value.
REQ-019 Two or more source enables active: DOE=0, ERR set.
REQ-020 Write FSM states: W_IDLE, W_ARMED, W_COMMIT.
REQ-021 W_IDLE -> W_ARMED when synchronised n_RAMW=0.
REQ-022 W_ARMED -> W_COMMIT when synchronised n_RAMW returns to 1.
REQ-023 In W_COMMIT, SHALL write DIN to RAM[ADD] (values sampled that cycle), increment WCNT, then go to W_IDLE; one cycle.
REQ-024 If synchronised n_RAMO=0 on any cycle in W_ARMED, SHALL set ERR and suppress the commit: W_COMMIT writes nothing and leaves WCNT unchanged.
REQ-025 A commit and a read of the same address in one cycle SHALL return old RAM data; new data appears from the next cycle.
REQ-026 LED SHALL load DIN on the cycle after a synchronised LEDLTCH 0->1 edge; a held-high LEDLTCH causes no further loads.
REQ-027 LEDLTCH edge while DOE=0 and no source enable active (floating bus) SHALL set ERR; LED still loads.
REQ-028 WCNT SHALL saturate at 255.
REQ-029 ERR SHALL clear only on reset.

Reset
REQ-030 n_CLR low SHALL immediately force DOUT=0, DOE=0, LED=0, ERR=0, WCNT=0, FSM=W_IDLE, and all synchroniser flops to their inactive level (1 for active-low strobes, 0 for LEDLTCH).
REQ-031 Reset SHALL clear all RAM words to 0.
REQ-032 Reset during W_ARMED SHALL abandon the write; no RAM change occurs after reset release until a new complete n_RAMW pulse.

Configuration
REQ-033 Macro WRITE_COUNT_EN defined: WCNT operates per REQ-023/028.
REQ-034 Macro WRITE_COUNT_EN undefined: WCNT is tied to 0 and the counter register is not built; all other behaviour is unchanged.

Verification
REQ-035 Reset, n_RAMO=0, ADD=3 -> DOE=1, DOUT=0x00 three edges after n_RAMO falls.
REQ-036 ADD=5, DIN=0xA7, n_RAMW pulse 4 cycles low, then n_RAMO=0 -> DOUT=0xA7, WCNT=1, ERR=0.
REQ-037 n_ROMO=0 and n_SWBEN=0 together -> DOE=0, ERR=1, and ERR stays 1 after both release.
REQ-038 n_RAMW low with n_RAMO low, DIN=0x55, ADD=2 -> RAM[2] stays 0x00, ERR=1, WCNT=0.
REQ-039 n_SWBEN=0, SW=0x3C, DIN=0x3C, LEDLTCH 0->1 held 10 cycles -> LED=0x3C, exactly one load; change DIN to 0x00 while LEDLTCH stays high -> LED stays 0x3C.
REQ-040 n_CLR pulsed low mid-write (W_ARMED, ADD=7, DIN=0xFF) -> RAM[7]=0x00, WCNT=0 after release; 256 further good writes -> WCNT=255.
